// File: rtl/signal_monitor_bfm.sv
// -----------------------------------------------------------------------------
// signal_monitor_bfm
//
// Synthesizable monitor stage placed behind the signal driver BFM. It samples
// the driven bus every clock, logs value changes with a timestamp, and runs an
// armed "wait-for-value" check with an optional timeout. Every event becomes a
// record in a small first-word-fall-through FIFO that the HVL proxy drains
// through a valid/ready port.
//
// Ports
//   clock          sampling clock
//   reset_n        asynchronous active-low reset
//   signals_in     monitored bus (driver output)
//   mon_enable     level; gates change recording and wait checks
//   arm            1-cycle pulse; starts a wait-for-value check
//   expect_value   value to wait for, captured on arm
//   expect_mask    compare mask (1 = compare), captured on arm
//   timeout_cycles wait limit in cycles, captured on arm; 0 = wait forever
//   waiting        high while the wait FSM is in WAIT
//   evt_valid      event FIFO is non-empty
//   evt_ready      consumer accepts the head record
//   evt_signals    sampled bus value of the head record
//   evt_timestamp  timestamp of the head record
//   evt_changed    head record: bus value changed
//   evt_match      head record: wait satisfied
//   evt_timeout    head record: wait timed out
//   overflow       sticky; a record was dropped on a full FIFO
//   overflow_clr   pulse; clears overflow
// -----------------------------------------------------------------------------
module signal_monitor_bfm #(
    parameter int SIGNAL_SIZE   = 4,
    parameter int TIMEOUT_WIDTH = 16,
    parameter int FIFO_DEPTH    = 8,
    parameter int TS_WIDTH      = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [SIGNAL_SIZE-1:0]   signals_in,
    input  logic                     mon_enable,
    input  logic                     arm,
    input  logic [SIGNAL_SIZE-1:0]   expect_value,
    input  logic [SIGNAL_SIZE-1:0]   expect_mask,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
    output logic                     waiting,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [SIGNAL_SIZE-1:0]   evt_signals,
    output logic [TS_WIDTH-1:0]      evt_timestamp,
    output logic                     evt_changed,
    output logic                     evt_match,
    output logic                     evt_timeout,
    output logic                     overflow,
    input  logic                     overflow_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = SIGNAL_SIZE + TS_WIDTH + 3;
    localparam logic [AW:0]            PTR_ONE = (AW+1)'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE = TIMEOUT_WIDTH'(1);
    localparam logic [TS_WIDTH-1:0]    TS_ONE  = TS_WIDTH'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } waitState_e;

    // Sampling pipeline and free-running timestamp
    logic [SIGNAL_SIZE-1:0] s1_q, s2_q;
    logic                   primed_q;
    logic [TS_WIDTH-1:0]    ts_q;

    // Wait FSM state and captured arm parameters
    waitState_e             state_q, state_d;
    logic [SIGNAL_SIZE-1:0] expVal_q, expVal_d;
    logic [SIGNAL_SIZE-1:0] expMask_q, expMask_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   tmoEn_q, tmoEn_d;

    // Event FIFO
    logic [RW-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]   wrPtr_q, rdPtr_q;
    logic          overflow_q, overflow_d;

    logic          changeEvt, matchEvt, timeoutEvt, hit;
    logic          fifoEmpty, fifoFull, popEvt, pushReq, pushAcc, dropEvt;
    logic [RW-1:0] record, head;

    // primed follows mon_enable one cycle late, so the first compare after
    // reset or after re-enabling never reports a change.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            primed_q <= 1'b0;
            ts_q     <= '0;
        end else begin
            s1_q     <= signals_in;
            s2_q     <= s1_q;
            primed_q <= mon_enable;
            ts_q     <= ts_q + TS_ONE;
        end
    end

    assign changeEvt = mon_enable & primed_q & (s1_q != s2_q);
    assign hit       = (((s1_q ^ expVal_q) & expMask_q) == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            expVal_q  <= '0;
            expMask_q <= '0;
            cnt_q     <= '0;
            tmoEn_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            expVal_q  <= expVal_d;
            expMask_q <= expMask_d;
            cnt_q     <= cnt_d;
            tmoEn_q   <= tmoEn_d;
        end
    end

    // A hit is checked before the countdown so that a match on the final
    // cycle wins over the timeout. Dropping mon_enable abandons the wait
    // silently.
    always_comb begin
        state_d    = state_q;
        expVal_d   = expVal_q;
        expMask_d  = expMask_q;
        cnt_d      = cnt_q;
        tmoEn_d    = tmoEn_q;
        matchEvt   = 1'b0;
        timeoutEvt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm && mon_enable) begin
                    state_d   = ST_WAIT;
                    expVal_d  = expect_value;
                    expMask_d = expect_mask;
                    cnt_d     = timeout_cycles;
                    tmoEn_d   = (timeout_cycles != '0);
                end
            end
            ST_WAIT: begin
                if (!mon_enable) begin
                    state_d = ST_IDLE;
                end else if (hit) begin
                    matchEvt = 1'b1;
                    state_d  = ST_IDLE;
                end else if (tmoEn_q) begin
                    if (cnt_q == CNT_ONE) begin
                        timeoutEvt = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign waiting = (state_q == ST_WAIT);

    // The extra pointer bit distinguishes full from empty when the index
    // bits are equal.
    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                       (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign popEvt    = !fifoEmpty && evt_ready;
    assign pushReq   = changeEvt | matchEvt | timeoutEvt;
    assign pushAcc   = pushReq && (!fifoFull || popEvt);
    assign dropEvt   = pushReq && fifoFull && !popEvt;
    assign record    = {s1_q, ts_q, changeEvt, matchEvt, timeoutEvt};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pushAcc) wrPtr_q <= wrPtr_q + PTR_ONE;
            if (popEvt)  rdPtr_q <= rdPtr_q + PTR_ONE;
            overflow_q <= overflow_d;
        end
    end

    // A fresh drop outranks a clear arriving in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (dropEvt) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Storage needs no reset: the outputs are forced to zero while empty.
    always_ff @(posedge clock) begin
        if (pushAcc) begin
            mem_q[wrPtr_q[AW-1:0]] <= record;
        end
    end

    assign evt_valid     = !fifoEmpty;
    assign head          = evt_valid ? mem_q[rdPtr_q[AW-1:0]] : '0;
    assign evt_signals   = head[RW-1 -: SIGNAL_SIZE];
    assign evt_timestamp = head[3 +: TS_WIDTH];
    assign evt_changed   = head[2];
    assign evt_match     = head[1];
    assign evt_timeout   = head[0];
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_signal_monitor_bfm.sv
// -----------------------------------------------------------------------------
// tb_signal_monitor_bfm
//
// Directed bench for signal_monitor_bfm. Inputs change 1 ns after a rising
// edge and outputs are sampled at that same point, so every check sees the
// state left by the most recent edge. Edge numbers in comments count rising
// edges after reset release (E1 is the first one).
// -----------------------------------------------------------------------------
module tb_signal_monitor_bfm;

    logic        clock;
    logic        reset_n;
    logic [3:0]  signals_in;
    logic        mon_enable;
    logic        arm;
    logic [3:0]  expect_value;
    logic [3:0]  expect_mask;
    logic [15:0] timeout_cycles;
    logic        waiting;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_signals;
    logic [31:0] evt_timestamp;
    logic        evt_changed;
    logic        evt_match;
    logic        evt_timeout;
    logic        overflow;
    logic        overflow_clr;

    int checkCount = 0;
    int errorCount = 0;

    signal_monitor_bfm #(
        .SIGNAL_SIZE  (4),
        .TIMEOUT_WIDTH(16),
        .FIFO_DEPTH   (8),
        .TS_WIDTH     (32)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .signals_in    (signals_in),
        .mon_enable    (mon_enable),
        .arm           (arm),
        .expect_value  (expect_value),
        .expect_mask   (expect_mask),
        .timeout_cycles(timeout_cycles),
        .waiting       (waiting),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_signals   (evt_signals),
        .evt_timestamp (evt_timestamp),
        .evt_changed   (evt_changed),
        .evt_match     (evt_match),
        .evt_timeout   (evt_timeout),
        .overflow      (overflow),
        .overflow_clr  (overflow_clr)
    );

    // 100 MHz clock, rising edges at 5, 15, 25 ns ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to 1 ns past the next rising edge.
    task automatic stepClock();
        @(posedge clock);
        #1;
    endtask

    // Drive the bus and let one rising edge capture it.
    task automatic applyStimulus(input logic [3:0] value);
        signals_in = value;
        stepClock();
    endtask

    // Pulse arm with the given wait parameters across one edge.
    task automatic armWait(input logic [3:0] val, input logic [3:0] mask,
                           input logic [15:0] tmo);
        arm            = 1'b1;
        expect_value   = val;
        expect_mask    = mask;
        timeout_cycles = tmo;
        stepClock();
        arm = 1'b0;
    endtask

    // Accept the current head record.
    task automatic popHead();
        evt_ready = 1'b1;
        stepClock();
        evt_ready = 1'b0;
    endtask

    task automatic checkHead(input string tag, input logic [3:0] sig,
                             input logic chg, input logic mat, input logic tmo);
        checkOutput({tag, "_valid"},   64'(evt_valid),   64'd1);
        checkOutput({tag, "_signals"}, 64'(evt_signals), 64'(sig));
        checkOutput({tag, "_changed"}, 64'(evt_changed), 64'(chg));
        checkOutput({tag, "_match"},   64'(evt_match),   64'(mat));
        checkOutput({tag, "_timeout"}, 64'(evt_timeout), 64'(tmo));
    endtask

    initial begin
        reset_n        = 1'b0;
        signals_in     = 4'h0;
        mon_enable     = 1'b1;
        arm            = 1'b0;
        expect_value   = 4'h0;
        expect_mask    = 4'h0;
        timeout_cycles = 16'd0;
        evt_ready      = 1'b0;
        overflow_clr   = 1'b0;

        // Reset state
        #2;
        checkOutput("rst_waiting",   64'(waiting),       64'd0);
        checkOutput("rst_valid",     64'(evt_valid),     64'd0);
        checkOutput("rst_overflow",  64'(overflow),      64'd0);
        checkOutput("rst_signals",   64'(evt_signals),   64'd0);
        checkOutput("rst_timestamp", 64'(evt_timestamp), 64'd0);
        repeat (2) stepClock();
        reset_n = 1'b1;

        // Change record: bus 0->5 captured at E3, record pushed at E4 with ts 3
        stepClock();                  // E1
        stepClock();                  // E2
        applyStimulus(4'h5);          // E3
        checkOutput("chg_early_valid", 64'(evt_valid), 64'd0);
        stepClock();                  // E4
        checkHead("chg", 4'h5, 1'b1, 1'b0, 1'b0);
        checkOutput("chg_ts", 64'(evt_timestamp), 64'd3);
        popHead();                    // E5
        checkOutput("chg_drained", 64'(evt_valid), 64'd0);

        // Wait for A, full mask, timeout 10; A captured at E9, record at E10
        armWait(4'hA, 4'hF, 16'd10);  // E6
        checkOutput("match_waiting", 64'(waiting), 64'd1);
        stepClock();                  // E7
        stepClock();                  // E8
        applyStimulus(4'hA);          // E9
        checkOutput("match_still_waiting", 64'(waiting), 64'd1);
        checkOutput("match_early_valid", 64'(evt_valid), 64'd0);
        stepClock();                  // E10
        checkHead("match", 4'hA, 1'b1, 1'b1, 1'b0);
        checkOutput("match_ts", 64'(evt_timestamp), 64'd9);
        checkOutput("match_done", 64'(waiting), 64'd0);
        popHead();                    // E11

        // Timeout 3: armed at E12, countdown at E13/E14, timeout at E15
        armWait(4'h3, 4'hF, 16'd3);   // E12
        stepClock();                  // E13
        stepClock();                  // E14
        checkOutput("tmo_waiting", 64'(waiting), 64'd1);
        checkOutput("tmo_early_valid", 64'(evt_valid), 64'd0);
        stepClock();                  // E15
        checkHead("tmo", 4'hA, 1'b0, 1'b0, 1'b1);
        checkOutput("tmo_ts", 64'(evt_timestamp), 64'd14);
        checkOutput("tmo_done", 64'(waiting), 64'd0);
        popHead();                    // E16

        // Masked compare: bus A (1010), low two bits equal 2, hits on first cycle
        armWait(4'h2, 4'h3, 16'd5);   // E17
        stepClock();                  // E18
        checkHead("mask", 4'hA, 1'b0, 1'b1, 1'b0);
        checkOutput("mask_ts", 64'(evt_timestamp), 64'd17);
        checkOutput("mask_done", 64'(waiting), 64'd0);
        popHead();                    // E19
        checkOutput("mask_drained", 64'(evt_valid), 64'd0);

        // Overflow: 10 changes with no consumer keeps the first 8
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i % 2 == 0) ? 4'h5 : 4'hA);
        end
        repeat (2) stepClock();
        checkOutput("ovf_set", 64'(overflow), 64'd1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("ovf_valid", 64'(evt_valid), 64'd1);
            checkOutput("ovf_order", 64'(evt_signals),
                        64'((i % 2 == 0) ? 4'h5 : 4'hA));
            popHead();
        end
        checkOutput("ovf_kept8", 64'(evt_valid), 64'd0);
        checkOutput("ovf_sticky", 64'(overflow), 64'd1);
        overflow_clr = 1'b1;
        stepClock();
        overflow_clr = 1'b0;
        checkOutput("ovf_clr", 64'(overflow), 64'd0);

        // Full FIFO with a pop in the same cycle as a push: nothing is lost
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(4'(i));
        end
        stepClock();                  // pushes record 8, FIFO now full
        checkOutput("full_ovf0", 64'(overflow), 64'd0);
        applyStimulus(4'h9);          // 9 captured, no push this edge
        evt_ready = 1'b1;
        stepClock();                  // push 9 and pop 1 together
        evt_ready = 1'b0;
        checkOutput("full_no_drop", 64'(overflow), 64'd0);
        for (int i = 2; i <= 9; i++) begin
            checkOutput("full_valid", 64'(evt_valid), 64'd1);
            checkOutput("full_order", 64'(evt_signals), 64'(i));
            popHead();
        end
        checkOutput("full_drained", 64'(evt_valid), 64'd0);

        // Timeout 0 waits indefinitely; dropping mon_enable aborts silently
        armWait(4'hF, 4'hF, 16'd0);
        repeat (4) stepClock();
        checkOutput("inf_waiting", 64'(waiting), 64'd1);
        mon_enable = 1'b0;
        stepClock();
        checkOutput("dis_idle", 64'(waiting), 64'd0);
        checkOutput("dis_no_record", 64'(evt_valid), 64'd0);
        mon_enable = 1'b1;
        repeat (2) stepClock();
        checkOutput("reen_no_record", 64'(evt_valid), 64'd0);

        // Async reset mid-WAIT with 3 queued records
        applyStimulus(4'h1);
        applyStimulus(4'h2);
        applyStimulus(4'h3);
        stepClock();
        armWait(4'hF, 4'hF, 16'd0);
        stepClock();
        checkOutput("pre_rst_waiting", 64'(waiting), 64'd1);
        checkOutput("pre_rst_valid", 64'(evt_valid), 64'd1);
        checkOutput("pre_rst_head", 64'(evt_signals), 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_waiting", 64'(waiting), 64'd0);
        checkOutput("async_valid", 64'(evt_valid), 64'd0);
        checkOutput("async_signals", 64'(evt_signals), 64'd0);
        checkOutput("async_overflow", 64'(overflow), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
